cgra_tid_dispatcher: RTL and testbench

Multi-lane thread-ID dispatcher for the CGRA subsystem. It issues a programmed inclusive TID range [base_tid, max_tid] as beats of up to LANES consecutive TIDs, using a valid/ready handshake toward the CGRA issue stage. It reports busy/done status and a running dispatch count. It sits between the kernel-launch control and the CGRA thread-issue front end.

---
 rtl/cgra_tid_dispatcher_if.sv | 27 ++
 rtl/cgra_tid_dispatcher.sv | 133 +++++++++++++
 tb/tb_cgra_tid_dispatcher.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_tid_dispatcher_if.sv
// Beat handshake between the TID dispatcher and the CGRA issue front end.
// One beat carries a lane-0 TID plus a mask of the lanes that hold live TIDs.
interface cgra_tid_dispatcher_if #(
  parameter int TOTAL_TID = 512,
  parameter int LANES     = 4
);
  localparam int TID_W = $clog2(TOTAL_TID + 1);

  logic             tid_valid;
  logic             tid_ready;
  logic [TID_W-1:0] tid_base;
  logic [LANES-1:0] lane_mask;

  modport master (
    output tid_valid,
    output tid_base,
    output lane_mask,
    input  tid_ready
  );

  modport slave (
    input  tid_valid,
    input  tid_base,
    input  lane_mask,
    output tid_ready
  );
endinterface

// File: rtl/cgra_tid_dispatcher.sv
// Issues an inclusive TID range as beats of up to LANES TIDs.
// Tracks busy/done status and the number of TIDs accepted downstream.
module cgra_tid_dispatcher #(
  parameter  int TOTAL_TID = 512,
  parameter  int LANES     = 4,
  localparam int TID_W     = $clog2(TOTAL_TID + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clr,
  input  logic [TID_W-1:0]      base_tid,
  input  logic [TID_W-1:0]      max_tid,
  cgra_tid_dispatcher_if.master tid,
  output logic                  busy,
  output logic                  done,
  output logic [TID_W:0]        disp_count
);
  localparam int W1 = TID_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DISP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic             valid_q;
  logic [TID_W-1:0] base_q;
  logic [TID_W-1:0] max_q;
  logic [LANES-1:0] mask_q;

  logic [TID_W-1:0] base_c;
  logic [TID_W-1:0] max_c;
  logic [LANES-1:0] mask_start;
  logic [LANES-1:0] mask_next;
  logic [W1-1:0]    nxt;
  logic             last;
  logic [W1-1:0]    pop;

  function automatic logic [TID_W-1:0] clamp(
    input logic [TID_W-1:0] v
  );
    if (int'(v) > TOTAL_TID)
      return TID_W'(TOTAL_TID);
    return v;
  endfunction

  // Extra top bit keeps base+i from wrapping near TOTAL_TID.
  function automatic logic [LANES-1:0] mk_mask(
    input logic [W1-1:0]    b,
    input logic [TID_W-1:0] m
  );
    logic [LANES-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i] = (b + W1'(i)) <= {1'b0, m};
    return r;
  endfunction

  assign base_c     = clamp(base_tid);
  assign max_c      = clamp(max_tid);
  assign mask_start = mk_mask({1'b0, base_c}, max_c);
  assign nxt        = {1'b0, base_q} + W1'(LANES);
  assign last       = nxt > {1'b0, max_q};
  assign mask_next  = mk_mask(nxt, max_q);

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++)
      pop = pop + W1'(mask_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      valid_q    <= 1'b0;
      base_q     <= '0;
      max_q      <= '0;
      mask_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      disp_count <= '0;
    end else if (clr) begin
      state      <= S_IDLE;
      valid_q    <= 1'b0;
      base_q     <= '0;
      max_q      <= '0;
      mask_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      disp_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            max_q      <= max_c;
            disp_count <= '0;
            if (base_c > max_c) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_DISP;
              valid_q <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
              base_q  <= base_c;
              mask_q  <= mask_start;
            end
          end
        end
        S_DISP: begin
          if (tid.tid_ready) begin
            disp_count <= disp_count + pop;
            if (last) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              mask_q  <= '0;
            end else begin
              base_q <= nxt[TID_W-1:0];
              mask_q <= mask_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tid.tid_valid = valid_q;
  assign tid.tid_base  = base_q;
  assign tid.lane_mask = mask_q;
endmodule

// File: tb/tb_cgra_tid_dispatcher.sv
// Scoreboard bench for cgra_tid_dispatcher (TOTAL_TID=512, LANES=4).
// Expected beats are queued at launch and popped as handshakes occur.
module tb_cgra_tid_dispatcher;
  localparam int TOT = 512;
  localparam int LN  = 4;
  localparam int TW  = $clog2(TOT + 1);

  typedef struct {
    int       base;
    logic [3:0] mask;
    bit       last;
  } beat_t;

  logic          clk = 0;
  logic          rst;
  logic          start;
  logic          clr;
  logic [TW-1:0] base_tid;
  logic [TW-1:0] max_tid;
  logic          busy;
  logic          done;
  logic [TW:0]   disp_count;

  cgra_tid_dispatcher_if #(.TOTAL_TID(TOT), .LANES(LN)) tif();

  cgra_tid_dispatcher #(.TOTAL_TID(TOT), .LANES(LN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clr        (clr),
    .base_tid   (base_tid),
    .max_tid    (max_tid),
    .tid        (tif),
    .busy       (busy),
    .done       (done),
    .disp_count (disp_count)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  beat_t sb[$];
  bit    exp_done = 0;
  bit    held = 0;
  int    prev_base;
  logic [3:0] prev_mask;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(int b, int m);
    logic [3:0] r;
    for (int i = 0; i < LN; i++) r[i] = (b + i) <= m;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_done) begin
        chk("done_lat", done, 1);
        chk("valid_off", tif.tid_valid, 0);
        exp_done = 0;
      end
      if (tif.tid_valid) begin
        if (held) begin
          chk("stall_base", tif.tid_base, prev_base);
          chk("stall_mask", tif.lane_mask, prev_mask);
        end
        if (tif.tid_ready) begin
          held = 0;
          if (sb.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            beat_t e;
            e = sb.pop_front();
            chk("beat_base", tif.tid_base, e.base);
            chk("beat_mask", tif.lane_mask, e.mask);
            exp_done = e.last;
          end
        end else begin
          held      = 1;
          prev_base = int'(tif.tid_base);
          prev_mask = tif.lane_mask;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic push_range(int bc, int mc, bit lastflag, output int cnt);
    cnt = 0;
    for (int t = bc; t <= mc; t += LN) begin
      beat_t e;
      e.base = t;
      e.mask = exp_mask(t, mc);
      e.last = lastflag && (t + LN > mc);
      sb.push_back(e);
      cnt += (mc - t + 1 >= LN) ? LN : (mc - t + 1);
    end
  endtask

  task automatic run(int b, int m, int mode, bit poke);
    int bc, mc, cnt, n;
    bc = b > TOT ? TOT : b;
    mc = m > TOT ? TOT : m;
    push_range(bc, mc, 1, cnt);
    @(posedge clk); #1;
    base_tid  = TW'(b);
    max_tid   = TW'(m);
    start     = 1;
    tif.tid_ready = 0;
    @(posedge clk); #1;
    start    = 0;
    base_tid = 0;
    max_tid  = '1;
    if (bc > mc) begin
      chk("empty_done", done, 1);
      chk("empty_valid", tif.tid_valid, 0);
    end else begin
      chk("first_valid", tif.tid_valid, 1);
      chk("first_base", tif.tid_base, bc);
      chk("first_busy", busy, 1);
    end
    n = 0;
    while (!done && n < 300) begin
      tif.tid_ready = (mode == 0) ? 1'b1 : (n % 4 == 0 || n % 4 == 3);
      start = poke && n == 1;
      if (poke && n == 1) begin
        base_tid = 100;
        max_tid  = 200;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    tif.tid_ready = 0;
    chk("timeout", n < 300, 1);
    chk("disp_count", disp_count, cnt);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("done_hold", done, 1);
    chk("busy_off", busy, 0);
    chk("valid_hold", tif.tid_valid, 0);
    sb.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, tif.tid_valid, 0);
    chk({tag, "_base"}, tif.tid_base, 0);
    chk({tag, "_mask"}, tif.lane_mask, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, disp_count, 0);
  endtask

  initial begin
    int cnt;
    rst = 1; start = 0; clr = 0;
    base_tid = 0; max_tid = 0;
    tif.tid_ready = 0;
    #12;
    chk_zero("reset");
    @(posedge clk); #1 rst = 0;

    run(0, 9, 0, 0);
    run(5, 5, 0, 0);
    run(7, 3, 0, 0);
    run(0, 15, 1, 0);
    run(508, 600, 0, 0);
    run(700, 800, 0, 0);
    run(0, 15, 0, 1);

    // Abort with clr after two accepted beats.
    push_range(0, 7, 0, cnt);
    @(posedge clk); #1;
    base_tid = 0; max_tid = 31; start = 1;
    @(posedge clk); #1;
    start = 0; tif.tid_ready = 1;
    @(posedge clk);
    @(posedge clk); #1;
    clr = 1; tif.tid_ready = 0;
    chk("pre_clr_cnt", disp_count, 8);
    @(posedge clk); #1;
    clr = 0;
    chk_zero("clr");
    chk("clr_sb", sb.size(), 0);
    sb.delete();

    // Asynchronous reset in the middle of a beat.
    push_range(0, 3, 0, cnt);
    @(posedge clk); #1;
    base_tid = 0; max_tid = 31; start = 1;
    @(posedge clk); #1;
    start = 0; tif.tid_ready = 1;
    @(posedge clk); #1;
    tif.tid_ready = 0;
    #1 rst = 1;
    #1 chk_zero("arst");
    chk("arst_sb", sb.size(), 0);
    sb.delete();
    exp_done = 0;
    @(posedge clk); #1 rst = 0;

    // clr beats a coincident start out of DONE.
    run(2, 2, 0, 0);
    @(posedge clk); #1;
    base_tid = 0; max_tid = 20; start = 1; clr = 1;
    @(posedge clk); #1;
    start = 0; clr = 0;
    chk_zero("clr_start");
    repeat (2) @(posedge clk);
    #1 chk("clr_start_idle", tif.tid_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
